// File: rtl/frame_sched_if.sv
`default_nettype none
// =============================================================================
// Module : frame_sched_if
// Video-in / encoder-out signal bundle for the per-frame scheduler.
// Rev    : 1.0
// =============================================================================
interface frame_sched_if #(
  parameter int DIV_W = 4,
  parameter int CNT_W = 16
) ();
  logic             enable;
  logic [DIV_W-1:0] decim;
  logic             pvalid_in;
  logic             vsync_in;
  logic [23:0]      ycbcr_in;
  logic             enc_busy;
  logic             fifo_afull;
  logic             pvalid_out;
  logic             vsync_out;
  logic [23:0]      ycbcr_out;
  logic             frame_start;
  logic             frame_done;
  logic [CNT_W-1:0] frames_enc;
  logic [CNT_W-1:0] frames_drop;
  logic [1:0]       state;

  modport master (
    output enable, decim, pvalid_in, vsync_in, ycbcr_in, enc_busy, fifo_afull,
    input  pvalid_out, vsync_out, ycbcr_out, frame_start, frame_done,
           frames_enc, frames_drop, state
  );

  modport slave (
    input  enable, decim, pvalid_in, vsync_in, ycbcr_in, enc_busy, fifo_afull,
    output pvalid_out, vsync_out, ycbcr_out, frame_start, frame_done,
           frames_enc, frames_drop, state
  );
endinterface
`default_nettype wire

// File: rtl/frame_sched.sv
`default_nettype none
// =============================================================================
// Module : frame_sched
// Per-frame admission scheduler ahead of the MJPEG encoder (decimation,
// enable gating, drop on bridge backpressure or encoder overrun).
// Rev    : 1.0
// =============================================================================
module frame_sched #(
  parameter int DIV_W = 4,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  frame_sched_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACTIVE = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  logic [DIV_W-1:0] r_phase;
  logic             r_vsync_d;
  logic             r_pvalid;
  logic             r_vsync;
  logic [23:0]      r_ycbcr;
  logic             r_start;
  logic             r_done;
  logic [CNT_W-1:0] r_enc;
  logic [CNT_W-1:0] r_drop;

  logic             w_vs_fall;
  logic             w_vs_rise;
  logic [DIV_W-1:0] w_phase_next;
  logic             w_drop_inc;
  logic             w_enc_inc;

  assign w_vs_fall    = ~bus.vsync_in & r_vsync_d;
  assign w_vs_rise    = bus.vsync_in & ~r_vsync_d;
  assign w_phase_next = (r_phase >= bus.decim) ? '0 : r_phase + 1'b1;

  // A frame is dropped when backpressure blocks an otherwise-due frame, or
  // when any frame boundary arrives while the encoder is still draining.
  assign w_drop_inc = w_vs_fall &
                      (((r_state == WAIT) & bus.enable & (r_phase == '0) & bus.fifo_afull) |
                       (r_state == DRAIN));
  assign w_enc_inc  = (r_state == DRAIN) & ~bus.enc_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_phase   <= '0;
      r_vsync_d <= 1'b0;
      r_pvalid  <= 1'b0;
      r_vsync   <= 1'b0;
      r_ycbcr   <= '0;
      r_start   <= 1'b0;
      r_done    <= 1'b0;
      r_enc     <= '0;
      r_drop    <= '0;
    end else begin
      r_vsync_d <= bus.vsync_in;
      r_ycbcr   <= bus.ycbcr_in;
      r_pvalid  <= bus.pvalid_in & (r_state == ACTIVE);
      r_vsync   <= bus.vsync_in & (r_state != IDLE);
      r_start   <= 1'b0;
      r_done    <= 1'b0;

      if (w_vs_fall && (r_state != IDLE)) r_phase <= w_phase_next;
      if (w_drop_inc && (r_drop != C_CNT_MAX)) r_drop <= r_drop + 1'b1;
      if (w_enc_inc && (r_enc != C_CNT_MAX)) r_enc <= r_enc + 1'b1;

      case (r_state)
        IDLE: begin
          if (bus.enable) begin
            r_state <= WAIT;
            r_phase <= '0;
          end
        end
        WAIT: begin
          if (w_vs_fall) begin
            if (!bus.enable) begin
              r_state <= IDLE;
            end else if ((r_phase == '0) && !bus.fifo_afull) begin
              r_state <= ACTIVE;
              r_start <= 1'b1;
            end
          end
        end
        ACTIVE: begin
          if (w_vs_rise) r_state <= DRAIN;
        end
        DRAIN: begin
          // A boundary coinciding with completion is counted as dropped
          // above and is never admitted from here.
          if (!bus.enc_busy) begin
            r_state <= WAIT;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.pvalid_out  = r_pvalid;
  assign bus.vsync_out   = r_vsync;
  assign bus.ycbcr_out   = r_ycbcr;
  assign bus.frame_start = r_start;
  assign bus.frame_done  = r_done;
  assign bus.frames_enc  = r_enc;
  assign bus.frames_drop = r_drop;
  assign bus.state       = r_state;
endmodule
`default_nettype wire

// File: tb/tb_frame_sched.sv
`default_nettype none
// =============================================================================
// Module : tb_frame_sched
// Scoreboard bench for frame_sched: expected events/pixels queued by the
// stimulus, popped by a monitor when the DUT presents them.
// Rev    : 1.0
// =============================================================================
module tb_frame_sched;
  logic clk;
  logic rst_n;
  logic rst_sat_n;

  frame_sched_if #(.DIV_W(4), .CNT_W(16)) bus ();
  frame_sched_if #(.DIV_W(4), .CNT_W(3))  sbus ();

  frame_sched #(.DIV_W(4), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Narrow-counter copy sharing the same stimulus, for saturation.
  frame_sched #(.DIV_W(4), .CNT_W(3)) dut_sat (
    .clk   (clk),
    .rst_n (rst_sat_n),
    .bus   (sbus)
  );

  assign sbus.enable     = bus.enable;
  assign sbus.decim      = bus.decim;
  assign sbus.pvalid_in  = bus.pvalid_in;
  assign sbus.vsync_in   = bus.vsync_in;
  assign sbus.ycbcr_in   = bus.ycbcr_in;
  assign sbus.enc_busy   = bus.enc_busy;
  assign sbus.fifo_afull = bus.fifo_afull;

  typedef struct packed {
    logic        is_done;
    logic [15:0] enc;
    logic [15:0] drop;
  } ev_t;

  ev_t         evq[$];
  logic [23:0] pixq[$];
  ev_t         mon_ev;
  logic [23:0] mon_pix;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_enc = 16'd0;
  logic [15:0] exp_drop = 16'd0;
  int          tot_enc = 0;
  logic [7:0]  fid = 8'd0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every presented event or pixel must match the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.frame_start || bus.frame_done) begin
        if (evq.size() == 0) begin
          check("unexpected_event", {30'd0, bus.frame_start, bus.frame_done}, 32'd0);
        end else begin
          mon_ev = evq.pop_front();
          check("event_kind", {31'd0, bus.frame_done}, {31'd0, mon_ev.is_done});
          check("event_frames_enc", {16'd0, bus.frames_enc}, {16'd0, mon_ev.enc});
          check("event_frames_drop", {16'd0, bus.frames_drop}, {16'd0, mon_ev.drop});
        end
      end
      if (bus.pvalid_out) begin
        if (pixq.size() == 0) begin
          check("unexpected_pixel", {8'd0, bus.ycbcr_out}, 32'hFFFFFFFF);
        end else begin
          mon_pix = pixq.pop_front();
          check("pixel_data", {8'd0, bus.ycbcr_out}, {8'd0, mon_pix});
        end
      end
    end
  end

  // One frame: boundary, a blank line, 4 pixels, then closing vsync + blanking.
  task automatic do_frame(input bit admit, input bit drop, input bit auto_done, input bit kill_en);
    if (admit) evq.push_back('{1'b0, exp_enc, exp_drop});
    if (drop) exp_drop++;
    bus.vsync_in = 1'b0;
    tick(2);
    for (int i = 0; i < 4; i++) begin
      bus.pvalid_in = 1'b1;
      bus.ycbcr_in  = {fid, 8'(i), 8'hA5};
      if (admit) pixq.push_back(bus.ycbcr_in);
      if (kill_en && i == 1) bus.enable = 1'b0;
      tick(1);
    end
    bus.pvalid_in = 1'b0;
    tick(1);
    if (admit && auto_done) begin
      exp_enc++;
      tot_enc++;
      evq.push_back('{1'b1, exp_enc, exp_drop});
    end
    bus.vsync_in = 1'b1;
    tick(4);
    fid++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    rst_sat_n = 1'b0;
    bus.enable = 1'b0;
    bus.decim = 4'd0;
    bus.pvalid_in = 1'b0;
    bus.vsync_in = 1'b1;
    bus.ycbcr_in = 24'd0;
    bus.enc_busy = 1'b0;
    bus.fifo_afull = 1'b0;
    tick(3);
    rst_n = 1'b1;
    rst_sat_n = 1'b1;
    tick(2);

    // Reset state
    check("reset_state", {30'd0, bus.state}, 32'd0);
    check("reset_vsync_out", {31'd0, bus.vsync_out}, 32'd0);
    check("reset_pvalid_out", {31'd0, bus.pvalid_out}, 32'd0);
    check("reset_frames_enc", {16'd0, bus.frames_enc}, 32'd0);

    bus.enable = 1'b1;
    tick(2);
    check("enable_to_wait", {30'd0, bus.state}, 32'd1);

    // Every frame admitted
    for (int f = 0; f < 4; f++) do_frame(1'b1, 1'b0, 1'b1, 1'b0);
    check("t1_frames_enc", {16'd0, bus.frames_enc}, 32'd4);
    check("t1_frames_drop", {16'd0, bus.frames_drop}, 32'd0);

    // 1-in-3 decimation
    bus.decim = 4'd2;
    for (int f = 0; f < 9; f++) do_frame(f % 3 == 0, 1'b0, 1'b1, 1'b0);
    check("t2_frames_enc", {16'd0, bus.frames_enc}, 32'd7);
    check("t2_frames_drop", {16'd0, bus.frames_drop}, 32'd0);

    // Backpressure skip
    bus.decim = 4'd0;
    do_frame(1'b1, 1'b0, 1'b1, 1'b0);
    bus.fifo_afull = 1'b1;
    do_frame(1'b0, 1'b1, 1'b0, 1'b0);
    bus.fifo_afull = 1'b0;
    do_frame(1'b1, 1'b0, 1'b1, 1'b0);
    check("t3_frames_drop", {16'd0, bus.frames_drop}, 32'd1);

    // Encoder overrun across two boundaries
    bus.enc_busy = 1'b1;
    do_frame(1'b1, 1'b0, 1'b0, 1'b0);
    do_frame(1'b0, 1'b1, 1'b0, 1'b0);
    do_frame(1'b0, 1'b1, 1'b0, 1'b0);
    check("t4_state_drain", {30'd0, bus.state}, 32'd3);
    check("t4_frames_drop", {16'd0, bus.frames_drop}, 32'd3);
    exp_enc++;
    tot_enc++;
    evq.push_back('{1'b1, exp_enc, exp_drop});
    bus.enc_busy = 1'b0;
    tick(2);
    check("t4_state_wait", {30'd0, bus.state}, 32'd1);

    // Enable dropped mid-frame, then re-enabled with phase cleared
    bus.decim = 4'd3;
    do_frame(1'b1, 1'b0, 1'b1, 1'b1);
    check("t5_state_wait_after_done", {30'd0, bus.state}, 32'd1);
    do_frame(1'b0, 1'b0, 1'b0, 1'b0);
    check("t5_state_idle", {30'd0, bus.state}, 32'd0);
    check("t5_vsync_out_idle", {31'd0, bus.vsync_out}, 32'd0);
    bus.enable = 1'b1;
    tick(2);
    check("t5_reenable_wait", {30'd0, bus.state}, 32'd1);
    do_frame(1'b1, 1'b0, 1'b1, 1'b0);
    bus.decim = 4'd0;
    do_frame(1'b0, 1'b0, 1'b0, 1'b0);
    check("t5_frames_enc", {16'd0, bus.frames_enc}, 32'(tot_enc));

    // Saturating narrow counters
    check("sat_frames_enc", {29'd0, sbus.frames_enc}, (tot_enc > 7) ? 32'd7 : 32'(tot_enc));
    check("sat_frames_drop", {29'd0, sbus.frames_drop}, (exp_drop > 7) ? 32'd7 : {16'd0, exp_drop});

    // Asynchronous reset in the middle of an active frame
    evq.push_back('{1'b0, exp_enc, exp_drop});
    bus.vsync_in = 1'b0;
    tick(2);
    for (int i = 0; i < 3; i++) begin
      bus.pvalid_in = 1'b1;
      bus.ycbcr_in  = {fid, 8'(i), 8'h5A};
      pixq.push_back(bus.ycbcr_in);
      tick(1);
    end
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_pvalid_out", {31'd0, bus.pvalid_out}, 32'd0);
    check("arst_vsync_out", {31'd0, bus.vsync_out}, 32'd0);
    check("arst_state", {30'd0, bus.state}, 32'd0);
    check("arst_frames_enc", {16'd0, bus.frames_enc}, 32'd0);
    check("arst_frames_drop", {16'd0, bus.frames_drop}, 32'd0);
    pixq.delete();
    bus.pvalid_in = 1'b0;
    bus.vsync_in = 1'b1;
    fid++;
    @(negedge clk);
    rst_n = 1'b1;
    exp_enc = 16'd0;
    exp_drop = 16'd0;
    tick(3);
    check("post_reset_wait", {30'd0, bus.state}, 32'd1);
    do_frame(1'b1, 1'b0, 1'b1, 1'b0);
    check("post_reset_frames_enc", {16'd0, bus.frames_enc}, 32'd1);

    tick(4);
    check("event_queue_drained", 32'(evq.size()), 32'd0);
    check("pixel_queue_drained", 32'(pixq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/frame_sched.md
Name: frame_sched

Overview:
- Per-frame scheduler between the TMDS/YCbCr front end and the MJPEG encoder.
- Decides which frames the encoder sees: rate decimation, enable control, and skipping on bridge-FIFO backpressure.
- Never opens a frame while the encoder is still emitting the previous one.
- Replaces the ad-hoc frame_mask logic and feeds the encoder's pvalid/vsync/ycbcr inputs.

Parameters:
DIV_W, 4, width of decimation ratio input
CNT_W, 16, width of encoded/dropped frame counters

Ports:
clk  in  1  pixel/data clock
rst_n  in  1  reset, asynchronous, active-low
enable  in  1  capture enable (level)
decim  in  DIV_W  encode 1 of every decim+1 frames; 0 = every frame
pvalid_in  in  1  pixel valid from token decode
vsync_in  in  1  vsync from token decode
ycbcr_in  in  24  pixel data
enc_busy  in  1  encoder still producing JPEG bytes for the current frame
fifo_afull  in  1  enc-to-eth bridge FIFO almost full
pvalid_out  out  1  gated pixel valid to encoder
vsync_out  out  1  gated vsync to encoder
ycbcr_out  out  24  registered pixel data to encoder
frame_start  out  1  1-cycle pulse when a frame is admitted
frame_done  out  1  1-cycle pulse when an admitted frame is fully encoded
frames_enc  out  CNT_W  count of completed frames, saturating
frames_drop  out  CNT_W  count of frames dropped for backpressure or overrun, saturating
state  out  2  current FSM state, for debug/LEDs

Behaviour:
Reset:
- All outputs 0; state = IDLE; phase = 0; vsync_d = 0.

Edge detection:
- vsync_d is vsync_in registered.
- vs_fall = ~vsync_in & vsync_d. Frame boundary = vs_fall, the start of a frame's vertical-active period.
- vs_rise = vsync_in & ~vsync_d, the end of that frame's active period.

Datapath, registered, 1-cycle latency:
- ycbcr_out <= ycbcr_in, unconditionally.
- pvalid_out <= pvalid_in & (state == ACTIVE).
- vsync_out <= vsync_in & (state != IDLE).

Phase counter (DIV_W bits):
- Cleared on IDLE->WAIT.
- Otherwise advances on every vs_fall while state != IDLE: phase becomes 0 when phase >= decim, else phase + 1.
- The decision below uses the pre-increment value.
- A decim change takes effect at the next wrap check.

FSM (state encoding IDLE=0, WAIT=1, ACTIVE=2, DRAIN=3):
- IDLE:
  - enable=1 -> WAIT on the next cycle.
  - A vs_fall in the same cycle is ignored; there is no decision that cycle.
- WAIT, on vs_fall:
  - enable=0 -> IDLE.
  - else phase != 0 -> stay WAIT (decimated; not counted as dropped).
  - else fifo_afull=1 -> stay WAIT, frames_drop++.
  - else -> ACTIVE, frame_start=1.
- ACTIVE:
  - On vs_rise -> DRAIN. The encoder sees the closing vsync on vsync_out.
  - enable deassert does not abort the frame.
- DRAIN:
  - enc_busy=0 -> WAIT, frame_done=1, frames_enc++.
  - vs_fall while enc_busy=1 (overrun) -> frames_drop++, phase advances, stay DRAIN.
  - If enc_busy falls in the same cycle as vs_fall: complete to WAIT, count the drop; the new frame is not admitted.

Counters:
- Saturate at all-ones; no wrap.
- Cleared only by reset.

Reset mid-operation:
- Asynchronous return to IDLE.
- pvalid_out and vsync_out drop to 0 immediately.

Never:
- pvalid_out=1 outside ACTIVE+1 cycle.
- frame_start while enc_busy=1 in ACTIVE.
- Two frame_start pulses without an intervening frame_done.

Test Plan:
- enable=1, decim=0, 4 frames, enc_busy low before each next vs_fall, fifo_afull=0 -> 4 frame_start, 4 frame_done, frames_enc=4, frames_drop=0, pvalid_out = pvalid_in delayed 1 cycle.
- decim=2, 9 frames -> frames 0, 3, 6 admitted; frames_enc=3; frames_drop=0; pvalid_out=0 throughout the other frames.
- fifo_afull=1 at the vs_fall of frame 1, decim=0 -> frame 1 skipped, frames_drop=1; frame 2 admitted.
- enc_busy held high across two vs_fall edges after frame 0 -> both following frames dropped (frames_drop=2), state stays DRAIN (3); enc_busy low -> frame_done, WAIT.
- enable deasserted mid-ACTIVE -> frame completes through DRAIN, then IDLE at the next vs_fall; vsync_out=0 in IDLE; re-enable -> phase=0, next frame admitted.
- rst_n pulled low mid-ACTIVE, asynchronously, not on an edge -> pvalid_out, vsync_out, counters and state read 0 before the next clk edge.
- frames_enc preloaded near the limit by running 2^CNT_W+2 frames with CNT_W overridden to 3 -> frames_enc sticks at 7.
